// File: rtl/sap1_out_display.sv
// sap1_out_display: SAP-1 output value to BCD via sequential double-dabble,
// shown on a 3-digit multiplexed 7-segment display with a sticky halt dp.
module sap1_out_display #(
   parameter int REFRESH_DIV = 1000,
   parameter bit BLANK_LEAD  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  out_value,
   input  logic        halt,
   output logic [11:0] bcd,
   output logic        conv_busy,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [2:0]  an
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] R_LAST = CW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t      state;
   logic [7:0]  cap_value;
   logic [7:0]  bin;
   logic [11:0] scratch;
   logic [11:0] adj;
   logic [2:0]  step;

   logic [CW-1:0] rcnt;
   logic [1:0]    idx;
   logic [1:0]    nidx;
   logic          wrap;
   logic          halt_seen;
   logic [3:0]    digit;
   logic          blank;
   logic [6:0]    seg_next;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // add-3 correction applied to every scratch nibble before each shift
   always_comb begin
      adj = scratch;
      for (int i = 0; i < 3; i++) begin
         if (scratch[i*4 +: 4] >= 4'd5)
            adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
      end
   end

   // conversion FSM: load on a new value, 8 shift steps, then publish
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cap_value <= 8'h00;
         bin       <= 8'h00;
         scratch   <= 12'h000;
         step      <= 3'd0;
         bcd       <= 12'h000;
         conv_busy <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (out_value != cap_value) begin
                  cap_value <= out_value;
                  bin       <= out_value;
                  scratch   <= 12'h000;
                  step      <= 3'd0;
                  conv_busy <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               {scratch, bin} <= {adj[10:0], bin, 1'b0};
               step <= step + 3'd1;
               if (step == 3'd7)
                  state <= DONE;
            end
            DONE: begin
               bcd       <= scratch;
               conv_busy <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // next digit index and its segment pattern, from the published bcd only
   always_comb begin
      wrap  = (rcnt == R_LAST);
      nidx  = idx;
      if (wrap)
         nidx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      digit = bcd[3:0];
      blank = 1'b0;
      unique case (1'b1)
         nidx == 2'd2: begin
            digit = bcd[11:8];
            blank = BLANK_LEAD && (bcd[11:8] == 4'd0);
         end
         nidx == 2'd1: begin
            digit = bcd[7:4];
            blank = BLANK_LEAD && (bcd[11:8] == 4'd0)
                    && (bcd[7:4] == 4'd0);
         end
         default: digit = bcd[3:0];
      endcase
      seg_next = blank ? 7'h00 : seg_of(digit);
   end

   // refresh scan: an, seg and dp registered together to avoid ghosting
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcnt      <= '0;
         idx       <= 2'd0;
         an        <= 3'b001;
         seg       <= 7'h3F;
         dp        <= 1'b0;
         halt_seen <= 1'b0;
      end else begin
         rcnt      <= wrap ? '0 : rcnt + 1'b1;
         idx       <= nidx;
         an        <= 3'b001 << nidx;
         seg       <= seg_next;
         dp        <= (nidx == 2'd0) && (halt_seen || halt);
         halt_seen <= halt_seen || halt;
      end
   end

endmodule

// File: tb/tb_sap1_out_display.sv
// tb_sap1_out_display: directed stimulus plus an arithmetic reference model
// of the display pipeline, checked every cycle against two DUT variants.
module tb_sap1_out_display;

   localparam int RDIV = 4;

   logic        clk;
   logic        reset;
   logic [7:0]  out_value;
   logic        halt;
   logic [11:0] bcd, bcd_nb;
   logic        conv_busy, busy_nb;
   logic [6:0]  seg, seg_nb;
   logic        dp, dp_nb;
   logic [2:0]  an, an_nb;

   int pass_cnt = 0;
   int total_cnt = 0;

   sap1_out_display #(.REFRESH_DIV(RDIV), .BLANK_LEAD(1'b1)) u_dut (
      .clk(clk), .reset(reset), .out_value(out_value), .halt(halt),
      .bcd(bcd), .conv_busy(conv_busy), .seg(seg), .dp(dp), .an(an)
   );

   sap1_out_display #(.REFRESH_DIV(RDIV), .BLANK_LEAD(1'b0)) u_nb (
      .clk(clk), .reset(reset), .out_value(out_value), .halt(halt),
      .bcd(bcd_nb), .conv_busy(busy_nb), .seg(seg_nb), .dp(dp_nb),
      .an(an_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      else
         pass_cnt++;
   endtask

   function automatic logic [6:0] seg_tab(input int d);
      logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return t[d];
   endfunction

   // reference model: value-level conversion latency, decimal digits
   int m_cap, m_cnt, m_val, m_tick, m_idx, m_old, m_d, m_h, m_t;
   bit m_halt;
   logic [11:0] e_bcd;
   logic        e_busy, e_dp;
   logic [2:0]  e_an;
   logic [6:0]  e_seg1, e_seg0;

   always @(posedge clk) begin
      if (!reset) begin
         m_cap = 0; m_cnt = 0; m_val = 0;
         m_tick = 0; m_idx = 0; m_halt = 0;
         e_an = 3'b001; e_seg1 = 7'h3F; e_seg0 = 7'h3F; e_dp = 1'b0;
      end else begin
         m_old = m_val;
         if (m_cnt == 0) begin
            if (int'(out_value) != m_cap) begin
               m_cap = int'(out_value);
               m_cnt = 9;
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) m_val = m_cap;
         end
         m_halt = m_halt || halt;
         if (m_tick == RDIV - 1) begin
            m_tick = 0;
            m_idx = (m_idx + 1) % 3;
         end else begin
            m_tick++;
         end
         m_h = m_old / 100;
         m_t = (m_old / 10) % 10;
         m_d = (m_idx == 0) ? m_old % 10 : (m_idx == 1) ? m_t : m_h;
         e_an = 3'(1 << m_idx);
         e_seg0 = seg_tab(m_d);
         e_seg1 = seg_tab(m_d);
         if (m_idx == 2 && m_h == 0) e_seg1 = 7'h00;
         if (m_idx == 1 && m_h == 0 && m_t == 0) e_seg1 = 7'h00;
         e_dp = (m_idx == 0) && m_halt;
      end
      e_bcd = {4'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10)};
      e_busy = (m_cnt != 0);
      #2;
      check("m_bcd", 32'(bcd), 32'(e_bcd));
      check("m_bcd_nb", 32'(bcd_nb), 32'(e_bcd));
      check("m_busy", 32'(conv_busy), 32'(e_busy));
      check("m_an", 32'(an), 32'(e_an));
      check("m_an_nb", 32'(an_nb), 32'(e_an));
      check("m_seg", 32'(seg), 32'(e_seg1));
      check("m_seg_nb", 32'(seg_nb), 32'(e_seg0));
      check("m_dp", 32'(dp), 32'(e_dp));
      check("m_dp_nb", 32'(dp_nb), 32'(e_dp));
   end

   task automatic show_digits(input logic [6:0] o1, t1, h1, o0, t0, h0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         case (an)
            3'b001: begin
               check("dig_ones", 32'(seg), 32'(o1));
               check("dig_ones_nb", 32'(seg_nb), 32'(o0));
            end
            3'b010: begin
               check("dig_tens", 32'(seg), 32'(t1));
               check("dig_tens_nb", 32'(seg_nb), 32'(t0));
            end
            3'b100: begin
               check("dig_hund", 32'(seg), 32'(h1));
               check("dig_hund_nb", 32'(seg_nb), 32'(h0));
            end
            default: check("dig_an_onehot", 32'(an), 32'b001);
         endcase
      end
   endtask

   initial begin
      int nbusy;
      int waited;
      logic [2:0] exp_an;
      reset = 1'b0;
      out_value = 8'd0;
      halt = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bcd", 32'(bcd), 32'h000);
      check("rst_busy", 32'(conv_busy), 32'd0);
      check("rst_an", 32'(an), 32'b001);
      check("rst_seg", 32'(seg), 32'h3F);
      check("rst_dp", 32'(dp), 32'd0);
      reset = 1'b1;

      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("t1_busy", 32'(conv_busy), 32'd0);
         if (an == 3'b001) check("t1_seg", 32'(seg), 32'h3F);
      end

      out_value = 8'd255;
      nbusy = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (conv_busy) nbusy++;
      end
      check("t2_busy_len", 32'(nbusy), 32'd9);
      check("t2_bcd", 32'(bcd), 32'h255);
      show_digits(7'h6D, 7'h6D, 7'h5B, 7'h6D, 7'h6D, 7'h5B);

      out_value = 8'd7;
      repeat (12) @(negedge clk);
      check("t3_bcd", 32'(bcd), 32'h007);
      show_digits(7'h07, 7'h00, 7'h00, 7'h07, 7'h3F, 7'h3F);

      out_value = 8'd100;
      repeat (3) @(negedge clk);
      out_value = 8'd42;
      repeat (6) @(negedge clk);
      check("t4_pre_e9", 32'(bcd), 32'h007);
      @(negedge clk);
      check("t4_e9_bcd", 32'(bcd), 32'h100);
      check("t4_e9_idle", 32'(conv_busy), 32'd0);
      @(negedge clk);
      check("t4_new_e0", 32'(conv_busy), 32'd1);
      repeat (8) @(negedge clk);
      check("t4_pre_e9b", 32'(bcd), 32'h100);
      @(negedge clk);
      check("t4_bcd_42", 32'(bcd), 32'h042);

      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      waited = 0;
      while (an != 3'b100 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      while (an != 3'b001 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("t5_scan_found", 32'(waited < 20), 32'd1);
      for (int i = 0; i < 12; i++) begin
         exp_an = (i < 4) ? 3'b001 : (i < 8) ? 3'b010 : 3'b100;
         check("t5_an", 32'(an), 32'(exp_an));
         check("t5_dp", 32'(dp), 32'(i < 4));
         @(negedge clk);
      end

      out_value = 8'd200;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      check("t6_busy", 32'(conv_busy), 32'd0);
      check("t6_bcd", 32'(bcd), 32'h000);
      check("t6_an", 32'(an), 32'b001);
      check("t6_seg", 32'(seg), 32'h3F);
      check("t6_dp", 32'(dp), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      waited = 0;
      while (bcd != 12'h200 && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      check("t6_reconv", 32'(bcd), 32'h200);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("t6_dp_clr", 32'(dp), 32'd0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
